// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a 4-entry colour palette and a registered pixel stage.
// Stage 0 exposes the raw counters; stage 1 registers sync, blanking and colour one clock later.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned CNT_W    = 11
) (
    input  logic                 clk25MHz,
    input  logic                 rst_n,
    input  logic [1:0]           pix_idx,
    input  logic                 pal_we,
    input  logic [1:0]           pal_addr,
    input  logic [3*COLOR_W-1:0] pal_data,
    output logic [CNT_W-1:0]     pixel_x,
    output logic [CNT_W-1:0]     pixel_y,
    output logic                 pixel_req,
    output logic                 hsync,
    output logic                 vsync,
    output logic [COLOR_W-1:0]   R,
    output logic [COLOR_W-1:0]   G,
    output logic [COLOR_W-1:0]   B,
    output logic                 frame_start,
    output logic                 line_start,
    output logic                 vblank
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned RGB_W   = 3 * COLOR_W;

    localparam logic [CNT_W-1:0] HLast     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] VLast     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HAct      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VAct      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HSyncBeg  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HSyncEnd  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VSyncBeg  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VSyncEnd  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [RGB_W-1:0] ColWhite = '1;
    localparam logic [RGB_W-1:0] ColBlue  = RGB_W'((1 << COLOR_W) - 1);
    localparam logic [RGB_W-1:0] ColBlack = '0;
    localparam logic [RGB_W-1:0] ColRed   = ColBlue << (2 * COLOR_W);

    if (((H_TOTAL >> CNT_W) != 0) || ((V_TOTAL >> CNT_W) != 0)) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             vblank_q, vblank_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [RGB_W-1:0] pal_q [4];

    always_comb begin
        hcount_d = hcount_q + 1'b1;
        vcount_d = vcount_q;
        if (hcount_q == HLast) begin
            hcount_d = '0;
            vcount_d = (vcount_q == VLast) ? '0 : vcount_q + 1'b1;
        end
    end

    assign pixel_x     = hcount_q;
    assign pixel_y     = vcount_q;
    assign pixel_req   = (hcount_q < HAct) && (vcount_q < VAct);
    assign line_start  = (hcount_q == '0);
    assign frame_start = (hcount_q == '0) && (vcount_q == '0);

    // Stage 1 sees the palette before any same-edge write, so a write shows up one clock later.
    always_comb begin
        hsync_d  = ~SYNC_POL;
        vsync_d  = ~SYNC_POL;
        rgb_d    = '0;
        vblank_d = (vcount_q >= VAct);
        if ((hcount_q >= HSyncBeg) && (hcount_q < HSyncEnd)) begin
            hsync_d = SYNC_POL;
        end
        if ((vcount_q >= VSyncBeg) && (vcount_q < VSyncEnd)) begin
            vsync_d = SYNC_POL;
        end
        if (pixel_req) begin
            rgb_d = pal_q[pix_idx];
        end
    end

    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            vblank_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            vblank_q <= vblank_d;
            rgb_q    <= rgb_d;
        end
    end

    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            pal_q[0] <= ColWhite;
            pal_q[1] <= ColBlue;
            pal_q[2] <= ColBlack;
            pal_q[3] <= ColRed;
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_data;
        end
    end

    assign hsync  = hsync_q;
    assign vsync  = vsync_q;
    assign vblank = vblank_q;
    assign R      = rgb_q[RGB_W-1 -: COLOR_W];
    assign G      = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign B      = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, medium active-low, tiny active-high)
// run in lockstep against a time-indexed model of the raster and palette.
module tb_vga_timing_gen;

    localparam int N = 3;
    localparam logic [N-1:0][31:0] HA  = {32'd8, 32'd40, 32'd640};
    localparam logic [N-1:0][31:0] HF  = {32'd2, 32'd4,  32'd16};
    localparam logic [N-1:0][31:0] HSW = {32'd2, 32'd8,  32'd96};
    localparam logic [N-1:0][31:0] HBP = {32'd2, 32'd4,  32'd48};
    localparam logic [N-1:0][31:0] VA  = {32'd4, 32'd30, 32'd480};
    localparam logic [N-1:0][31:0] VF  = {32'd1, 32'd3,  32'd10};
    localparam logic [N-1:0][31:0] VSW = {32'd1, 32'd2,  32'd2};
    localparam logic [N-1:0][31:0] VBP = {32'd1, 32'd5,  32'd33};
    localparam logic [N-1:0]       POL = 3'b100;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pix_idx  [N];
    logic        pal_we   [N];
    logic [1:0]  pal_addr [N];
    logic [11:0] pal_data [N];
    logic [10:0] px [N];
    logic [10:0] py [N];
    logic        preq [N];
    logic        hs [N];
    logic        vs [N];
    logic        fs [N];
    logic        ls [N];
    logic        vb [N];
    logic [3:0]  r [N];
    logic [3:0]  g [N];
    logic [3:0]  b [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        vga_timing_gen #(
            .H_ACTIVE(HA[gi]), .H_FP(HF[gi]), .H_SYNC(HSW[gi]), .H_BP(HBP[gi]),
            .V_ACTIVE(VA[gi]), .V_FP(VF[gi]), .V_SYNC(VSW[gi]), .V_BP(VBP[gi]),
            .SYNC_POL(POL[gi]), .COLOR_W(4), .CNT_W(11)
        ) u_dut (
            .clk25MHz   (clk),
            .rst_n      (rst_n),
            .pix_idx    (pix_idx[gi]),
            .pal_we     (pal_we[gi]),
            .pal_addr   (pal_addr[gi]),
            .pal_data   (pal_data[gi]),
            .pixel_x    (px[gi]),
            .pixel_y    (py[gi]),
            .pixel_req  (preq[gi]),
            .hsync      (hs[gi]),
            .vsync      (vs[gi]),
            .R          (r[gi]),
            .G          (g[gi]),
            .B          (b[gi]),
            .frame_start(fs[gi]),
            .line_start (ls[gi]),
            .vblank     (vb[gi])
        );
    end

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Model: everything derives from t, the number of clock edges since reset release.
    int          t [N];
    bit          have_prev [N];
    int          prev_hc [N];
    int          prev_vc [N];
    logic [11:0] prev_col [N];
    logic [11:0] palm [N][4];
    int          pix_mode;
    logic [1:0]  pix_fixed;
    int          n_tests;
    int          n_fail;

    function automatic int ha(int i); return int'(HA[i]); endfunction
    function automatic int va(int i); return int'(VA[i]); endfunction
    function automatic int ht(int i); return int'(HA[i] + HF[i] + HSW[i] + HBP[i]); endfunction
    function automatic int vt(int i); return int'(VA[i] + VF[i] + VSW[i] + VBP[i]); endfunction
    function automatic int hcm(int i, int tt); return tt % ht(i); endfunction
    function automatic int vcm(int i, int tt); return (tt / ht(i)) % vt(i); endfunction

    function automatic logic [11:0] pal_default(int k);
        case (k)
            0:       return 12'hFFF;
            1:       return 12'h00F;
            2:       return 12'h000;
            default: return 12'hF00;
        endcase
    endfunction

    function automatic logic exp_hs(int i);
        int lo = int'(HA[i] + HF[i]);
        int hi = lo + int'(HSW[i]);
        if (!have_prev[i]) return ~POL[i];
        return (prev_hc[i] >= lo && prev_hc[i] < hi) ? POL[i] : ~POL[i];
    endfunction

    function automatic logic exp_vs(int i);
        int lo = int'(VA[i] + VF[i]);
        int hi = lo + int'(VSW[i]);
        if (!have_prev[i]) return ~POL[i];
        return (prev_vc[i] >= lo && prev_vc[i] < hi) ? POL[i] : ~POL[i];
    endfunction

    function automatic logic exp_vb(int i);
        return have_prev[i] && (prev_vc[i] >= va(i));
    endfunction

    function automatic logic [11:0] exp_rgb(int i);
        if (have_prev[i] && prev_hc[i] < ha(i) && prev_vc[i] < va(i)) return prev_col[i];
        return 12'h000;
    endfunction

    // {pixel_x, pixel_y, pixel_req, frame_start, line_start, hsync, vsync, vblank}
    function automatic logic [28:0] exp_ctrl(int i);
        int hc = hcm(i, t[i]);
        int vc = vcm(i, t[i]);
        return {11'(hc), 11'(vc), (hc < ha(i)) && (vc < va(i)), (hc == 0) && (vc == 0),
                (hc == 0), exp_hs(i), exp_vs(i), exp_vb(i)};
    endfunction

    // {pixel_x, pixel_y, pixel_req, hsync, vsync, vblank, frame_start, line_start, R, G, B}
    function automatic logic [39:0] reset_vec(int i);
        return {11'd0, 11'd0, 1'b1, ~POL[i], ~POL[i], 1'b0, 1'b1, 1'b1, 12'h000};
    endfunction

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            t[i]         = 0;
            have_prev[i] = 1'b0;
            pal_we[i]    = 1'b0;
            for (int k = 0; k < 4; k++) palm[i][k] = pal_default(k);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    // Drive pix_idx for the current stage-0 pixel, clock once, update the model, sample at +1.
    task automatic tick();
        for (int i = 0; i < N; i++) begin
            case (pix_mode)
                0:       pix_idx[i] = 2'($urandom_range(3));
                1:       pix_idx[i] = (hcm(i, t[i]) < ha(i) / 2) ? 2'd1 : 2'd0;
                default: pix_idx[i] = pix_fixed;
            endcase
            prev_hc[i]   = hcm(i, t[i]);
            prev_vc[i]   = vcm(i, t[i]);
            prev_col[i]  = palm[i][pix_idx[i]];
            have_prev[i] = 1'b1;
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (pal_we[i]) palm[i][pal_addr[i]] = pal_data[i];
            t[i]++;
        end
        #1;
        for (int i = 0; i < N; i++) pal_we[i] = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] got;
        logic [28:0] gotc;
        for (int i = 0; i < N; i++) begin
            pix_idx[i] = 2'd0; pal_addr[i] = 2'd0; pal_data[i] = 12'h000;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        reset_model();
        #4;
        for (int i = 0; i < N; i++) begin
            got = {px[i], py[i], preq[i], hs[i], vs[i], vb[i], fs[i], ls[i], r[i], g[i], b[i]};
            n_tests++;
            if (got !== reset_vec(i)) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: got %h, expected %h", i, got, reset_vec(i));
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            gotc = {px[i], py[i], preq[i], fs[i], ls[i], hs[i], vs[i], vb[i]};
            n_tests++;
            if (gotc !== exp_ctrl(i) || fs[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL release_cycle0 inst%0d: got %h, expected %h", i, gotc, exp_ctrl(i));
            end
        end
    endtask

    task automatic test_pixel_path();
        logic [11:0] want;
        pix_mode = 1;
        for (int k = 1; k <= 800; k++) begin
            tick();
            want = (k <= 320) ? 12'h00F : (k <= 640) ? 12'hFFF : 12'h000;
            n_tests++;
            if ({r[0], g[0], b[0]} !== want) begin
                n_fail++;
                $display("FAIL line0_rgb k=%0d: got %h, expected %h", k, {r[0], g[0], b[0]}, want);
            end
            for (int i = 1; i < N; i++) begin
                n_tests++;
                if ({r[i], g[i], b[i]} !== exp_rgb(i)) begin
                    n_fail++;
                    $display("FAIL split_rgb inst%0d t=%0d: got %h, expected %h",
                             i, t[i], {r[i], g[i], b[i]}, exp_rgb(i));
                end
            end
        end
    endtask

    task automatic test_palette_write();
        pix_mode  = 2;
        pix_fixed = 2'd2;
        for (int k = 0; k < 2000; k++) begin
            if (hcm(0, t[0]) >= 1 && hcm(0, t[0]) < ha(0) - 3 && vcm(0, t[0]) < va(0)) break;
            tick();
        end
        pal_we[0] = 1'b1; pal_addr[0] = 2'd2; pal_data[0] = 12'h0F0;
        tick();
        n_tests++;
        if ({r[0], g[0], b[0]} !== 12'h000) begin
            n_fail++;
            $display("FAIL pal_same_cycle: got %h, expected 000", {r[0], g[0], b[0]});
        end
        tick();
        n_tests++;
        if ({r[0], g[0], b[0]} !== 12'h0F0) begin
            n_fail++;
            $display("FAIL pal_next_cycle: got %h, expected 0F0", {r[0], g[0], b[0]});
        end
    endtask

    task automatic test_mid_reset();
        logic [39:0] got;
        logic [28:0] gotc;
        bit          found = 1'b0;
        pix_mode = 0;
        for (int k = 0; k < 5000; k++) begin
            if (vcm(0, t[0]) == 2 && hcm(0, t[0]) == 300) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_reset_position: got t=%0d, expected line 2 pixel 300", t[0]);
        end
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < N; i++) begin
            got = {px[i], py[i], preq[i], hs[i], vs[i], vb[i], fs[i], ls[i], r[i], g[i], b[i]};
            n_tests++;
            if (got !== reset_vec(i)) begin
                n_fail++;
                $display("FAIL async_reset inst%0d: got %h, expected %h", i, got, reset_vec(i));
            end
        end
        pulse_reset();
        #1;
        for (int i = 0; i < N; i++) begin
            gotc = {px[i], py[i], preq[i], fs[i], ls[i], hs[i], vs[i], vb[i]};
            n_tests++;
            if (gotc !== exp_ctrl(i)) begin
                n_fail++;
                $display("FAIL restart_origin inst%0d: got %h, expected %h", i, gotc, exp_ctrl(i));
            end
        end
        pix_mode  = 2;
        pix_fixed = 2'd2;
        tick();
        n_tests++;
        if ({r[0], g[0], b[0]} !== 12'h000) begin
            n_fail++;
            $display("FAIL pal_reverted: got %h, expected 000", {r[0], g[0], b[0]});
        end
        pix_fixed = 2'd3;
        tick();
        n_tests++;
        if ({r[0], g[0], b[0]} !== 12'hF00) begin
            n_fail++;
            $display("FAIL pal_default_red: got %h, expected F00", {r[0], g[0], b[0]});
        end
    endtask

    task automatic test_sync_timing();
        int          last_fs [N];
        int          last_ls [N];
        int          vs_cnt [N];
        int          hs_start [N];
        int          n_frames [N];
        logic        hs_prev [N];
        logic [28:0] gotc;
        pix_mode = 0;
        for (int i = 0; i < N; i++) begin
            last_fs[i] = -1; last_ls[i] = -1; vs_cnt[i] = 0; hs_start[i] = -1;
            n_frames[i] = 0; hs_prev[i] = hs[i];
        end
        for (int k = 0; k < 6800; k++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                gotc = {px[i], py[i], preq[i], fs[i], ls[i], hs[i], vs[i], vb[i]};
                n_tests++;
                if (gotc !== exp_ctrl(i)) begin
                    n_fail++;
                    $display("FAIL ctrl inst%0d t=%0d: got %h, expected %h",
                             i, t[i], gotc, exp_ctrl(i));
                end
                if (vs[i] === POL[i]) vs_cnt[i]++;
                if (fs[i] === 1'b1) begin
                    if (last_fs[i] >= 0) begin
                        n_frames[i]++;
                        n_tests += 2;
                        if (t[i] - last_fs[i] != ht(i) * vt(i)) begin
                            n_fail++;
                            $display("FAIL frame_period inst%0d: got %0d, expected %0d",
                                     i, t[i] - last_fs[i], ht(i) * vt(i));
                        end
                        if (vs_cnt[i] != int'(VSW[i]) * ht(i)) begin
                            n_fail++;
                            $display("FAIL vsync_clocks inst%0d: got %0d, expected %0d",
                                     i, vs_cnt[i], int'(VSW[i]) * ht(i));
                        end
                    end
                    last_fs[i] = t[i];
                    vs_cnt[i]  = 0;
                end
                if (ls[i] === 1'b1) begin
                    if (last_ls[i] >= 0) begin
                        n_tests++;
                        if (t[i] - last_ls[i] != ht(i)) begin
                            n_fail++;
                            $display("FAIL line_period inst%0d: got %0d, expected %0d",
                                     i, t[i] - last_ls[i], ht(i));
                        end
                    end
                    last_ls[i] = t[i];
                end
                if (hs[i] === POL[i] && hs_prev[i] !== POL[i]) begin
                    hs_start[i] = t[i];
                    n_tests++;
                    if (hcm(i, t[i]) != (int'(HA[i] + HF[i]) + 1) % ht(i)) begin
                        n_fail++;
                        $display("FAIL hsync_start inst%0d: got hcount %0d, expected %0d",
                                 i, hcm(i, t[i]), (int'(HA[i] + HF[i]) + 1) % ht(i));
                    end
                end
                if (hs[i] !== POL[i] && hs_prev[i] === POL[i] && hs_start[i] >= 0) begin
                    n_tests++;
                    if (t[i] - hs_start[i] != int'(HSW[i])) begin
                        n_fail++;
                        $display("FAIL hsync_width inst%0d: got %0d, expected %0d",
                                 i, t[i] - hs_start[i], int'(HSW[i]));
                    end
                end
                hs_prev[i] = hs[i];
            end
        end
        for (int i = 1; i < N; i++) begin
            n_tests++;
            if (n_frames[i] < 2) begin
                n_fail++;
                $display("FAIL frames_seen inst%0d: got %0d, expected at least 2", i, n_frames[i]);
            end
        end
    endtask

    task automatic test_random_palette();
        pix_mode = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) begin
                    pal_we[i]   = 1'b1;
                    pal_addr[i] = 2'($urandom_range(3));
                    pal_data[i] = 12'($urandom);
                end
            end
            tick();
            for (int i = 0; i < N; i++) begin
                n_tests++;
                if ({r[i], g[i], b[i]} !== exp_rgb(i)) begin
                    n_fail++;
                    $display("FAIL rand_rgb inst%0d t=%0d: got %h, expected %h",
                             i, t[i], {r[i], g[i], b[i]}, exp_rgb(i));
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pix_mode  = 0;
        pix_fixed = 2'd0;
        test_reset();
        test_pixel_path();
        test_palette_write();
        test_mid_reset();
        test_sync_timing();
        test_random_palette();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
